tdm_demux4: RTL and testbench
=============================

// Module: tdm_demux4
// PURPOSE
//  Registered 1-to-4 time-division demultiplexer. It is the receive-side counterpart of the
//  4:1 mux circuits (i1..i4 -> y_out): it takes a framed serial stream on d_in and rebuilds
//  the four channels on y1..y4.
//  It locks to a frame marker, counts slots and presents a complete frame atomically.
//  Sits between a serial link or mux output and any consumer of four parallel channels.
// PARAMETERS
//  WIDTH   1  bit width of each sample (d_in and y1..y4)
//  STRICT  1  1: a missing frame_sync at slot 0 while LOCKED is an error; 0: tolerated
// PORTS
//  clk         in   1      single clock; all state changes on rising edge
//  rst_n       in   1      asynchronous, active-low reset
//  d_in        in   WIDTH  serial sample, slot order i1,i2,i3,i4
//  in_valid    in   1      d_in qualifies this cycle; low = stall, all state held
//  frame_sync  in   1      marks the slot-0 (i1) beat; sampled only when in_valid=1
//  y1..y4      out  WIDTH  demuxed channels 1..4; update together, once per frame
//  frame_valid out  1      1-cycle pulse: y1..y4 just updated with a new frame
//  sync_err    out  1      1-cycle pulse: framing violation detected
//  locked      out  1      1 while FSM is in LOCKED
//  slot        out  2      index of next expected slot (0..3), 0 in HUNT
// BEHAVIOUR
//  Reset (rst_n=0, async): y1..y4=0, frame_valid=0, sync_err=0, locked=0, slot=0,
//   shadow regs=0, state=HUNT. Release takes effect on the first clk edge with rst_n=1.
//   A partial frame is discarded.
//  Beat = rising clk edge with in_valid=1. No beat: every register holds, pulses drop to 0.
//  FSM states: HUNT, LOCKED.
//  HUNT:
//   - A beat with frame_sync=0 is dropped.
//   - A beat with frame_sync=1 is stored: shadow0<=d_in, slot<=1, go LOCKED.
//  LOCKED, beat at slot k in 1..2: shadow_k<=d_in, slot<=k+1.
//  LOCKED, beat at slot 3:
//   - y1<=shadow0, y2<=shadow1, y3<=shadow2, y4<=d_in; frame_valid<=1; slot<=0.
//   - Latency: y1..y4 and frame_valid are valid on the edge that samples the 4th beat,
//     i.e. visible the cycle after it.
//  LOCKED, beat at slot 0 with frame_sync=1: normal; shadow0<=d_in, slot<=1.
//  LOCKED, beat at slot 0 with frame_sync=0:
//   - STRICT=1: sync_err<=1, beat dropped, slot<=0, go HUNT.
//   - STRICT=0: accepted as slot 0.
//  LOCKED, beat at slot 1..3 with frame_sync=1 (early marker): sync_err<=1, partial frame
//   discarded (y1..y4 untouched, no frame_valid), beat taken as new slot 0, slot<=1,
//   stay LOCKED.
//  y1..y4 never show a mixed frame: they change only on a completed slot-3 beat.
//  frame_valid and sync_err never assert in the same cycle. Both are registered and held
//   0 except for their 1-cycle pulses.
//  slot wraps 3->0. Stalls of any length between beats are legal and change nothing.
// TESTING
//  1 Reset mid-frame: lock, send 2 beats, pulse rst_n=0 -> all outputs 0, locked=0, next
//    frame with sync decodes cleanly.
//  2 Basic frame, WIDTH=1: sync beat 1, then 1,0,1 -> y1..y4=1,1,0,1, one frame_valid pulse,
//    slot back to 0.
//  3 HUNT: beats 1,0 with frame_sync=0, then synced frame 0,1,1,0 -> only y=0,1,1,0 is
//    output, locked rises after the sync beat.
//  4 Stalls: same frame as 2 with in_valid=0 for 3 cycles between each beat -> identical
//    y, a single frame_valid, no sync_err.
//  5 Early marker: after sync+1 beat, a frame_sync beat of 0 arrives -> sync_err pulse,
//    y unchanged; the next 3 beats 1,1,1 give y=0,1,1,1.
//  6 Missing marker: after a good frame, slot-0 beat without sync -> STRICT=1: sync_err,
//    locked=0; STRICT=0: accepted, no error.

Source files
------------

// File: rtl/tdm_demux4.sv
// Registered 1-to-4 TDM demultiplexer: locks to frame_sync and rebuilds four channels.
// Latency: y1..y4 and frame_valid update on the edge that samples the 4th beat (visible next cycle).
// Backpressure: none; in_valid=0 stalls and every register holds, pulse outputs drop to 0.
//
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_d_in, i_in_valid        serial sample (slot order i1..i4) and its qualifier
//   i_frame_sync              marks the slot-0 beat, sampled only on a beat
//   o_y1..o_y4                rebuilt channels, updated together once per frame
//   o_frame_valid, o_sync_err 1-cycle pulses: new frame / framing violation
//   o_locked, o_slot          FSM in LOCKED / next expected slot (0 in HUNT)
module tdm_demux4 #(
  parameter int WIDTH  = 1,
  parameter bit STRICT = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d_in,
  input  logic             i_in_valid,
  input  logic             i_frame_sync,
  output logic [WIDTH-1:0] o_y1,
  output logic [WIDTH-1:0] o_y2,
  output logic [WIDTH-1:0] o_y3,
  output logic [WIDTH-1:0] o_y4,
  output logic             o_frame_valid,
  output logic             o_sync_err,
  output logic             o_locked,
  output logic [1:0]       o_slot
);

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_slot, w_slot_nxt;
  logic [WIDTH-1:0] r_sh0, r_sh1, r_sh2;
  logic [WIDTH-1:0] w_sh0_nxt, w_sh1_nxt, w_sh2_nxt;
  logic [WIDTH-1:0] r_y1, r_y2, r_y3, r_y4;
  logic [WIDTH-1:0] w_y1_nxt, w_y2_nxt, w_y3_nxt, w_y4_nxt;
  logic             r_fv, w_fv_nxt;
  logic             r_serr, w_serr_nxt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_HUNT;
      r_slot  <= 2'd0;
      r_sh0   <= '0;
      r_sh1   <= '0;
      r_sh2   <= '0;
      r_y1    <= '0;
      r_y2    <= '0;
      r_y3    <= '0;
      r_y4    <= '0;
      r_fv    <= 1'b0;
      r_serr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_slot  <= w_slot_nxt;
      r_sh0   <= w_sh0_nxt;
      r_sh1   <= w_sh1_nxt;
      r_sh2   <= w_sh2_nxt;
      r_y1    <= w_y1_nxt;
      r_y2    <= w_y2_nxt;
      r_y3    <= w_y3_nxt;
      r_y4    <= w_y4_nxt;
      r_fv    <= w_fv_nxt;
      r_serr  <= w_serr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_slot_nxt  = r_slot;
    w_sh0_nxt   = r_sh0;
    w_sh1_nxt   = r_sh1;
    w_sh2_nxt   = r_sh2;
    w_y1_nxt    = r_y1;
    w_y2_nxt    = r_y2;
    w_y3_nxt    = r_y3;
    w_y4_nxt    = r_y4;
    w_fv_nxt    = 1'b0;
    w_serr_nxt  = 1'b0;

    if (i_in_valid) begin
      case (r_state)
        ST_HUNT: begin
          // Unmarked beats are dropped until a marker is seen.
          if (i_frame_sync) begin
            w_sh0_nxt   = i_d_in;
            w_slot_nxt  = 2'd1;
            w_state_nxt = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (r_slot == 2'd0) begin
            if (i_frame_sync || !STRICT) begin
              w_sh0_nxt  = i_d_in;
              w_slot_nxt = 2'd1;
            end else begin
              w_serr_nxt  = 1'b1;
              w_slot_nxt  = 2'd0;
              w_state_nxt = ST_HUNT;
            end
          end else if (i_frame_sync) begin
            // Early marker: abandon the partial frame and restart on this beat.
            w_serr_nxt = 1'b1;
            w_sh0_nxt  = i_d_in;
            w_slot_nxt = 2'd1;
          end else begin
            case (r_slot)
              2'd1: begin
                w_sh1_nxt  = i_d_in;
                w_slot_nxt = 2'd2;
              end
              2'd2: begin
                w_sh2_nxt  = i_d_in;
                w_slot_nxt = 2'd3;
              end
              default: begin
                // Last beat goes straight to y4 so the frame publishes atomically.
                w_y1_nxt   = r_sh0;
                w_y2_nxt   = r_sh1;
                w_y3_nxt   = r_sh2;
                w_y4_nxt   = i_d_in;
                w_fv_nxt   = 1'b1;
                w_slot_nxt = 2'd0;
              end
            endcase
          end
        end
        default: begin
          w_state_nxt = ST_HUNT;
          w_slot_nxt  = 2'd0;
        end
      endcase
    end
  end

  assign o_y1          = r_y1;
  assign o_y2          = r_y2;
  assign o_y3          = r_y3;
  assign o_y4          = r_y4;
  assign o_frame_valid = r_fv;
  assign o_sync_err    = r_serr;
  assign o_locked      = (r_state == ST_LOCKED);
  assign o_slot        = r_slot;

endmodule

// File: tb/tb_tdm_demux4.sv
// Testbench for tdm_demux4: strict and lenient instances share one stimulus stream.
// Checks every cycle against a frame-buffer reference model, plus directed frame checks.
// Stimulus includes random stalls, misplaced markers and asynchronous resets.
module tb_tdm_demux4;
  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] d_in;
  logic         in_valid;
  logic         frame_sync;

  logic [W-1:0] ys1, ys2, ys3, ys4, yl1, yl2, yl3, yl4;
  logic         fv_s, er_s, lk_s, fv_l, er_l, lk_l;
  logic [1:0]   sl_s, sl_l;

  int n_vec;
  int n_err;

  tdm_demux4 #(.WIDTH(W), .STRICT(1'b1)) u_strict (
    .i_clk(clk), .i_rst_n(rst_n), .i_d_in(d_in), .i_in_valid(in_valid),
    .i_frame_sync(frame_sync), .o_y1(ys1), .o_y2(ys2), .o_y3(ys3), .o_y4(ys4),
    .o_frame_valid(fv_s), .o_sync_err(er_s), .o_locked(lk_s), .o_slot(sl_s)
  );

  tdm_demux4 #(.WIDTH(W), .STRICT(1'b0)) u_lenient (
    .i_clk(clk), .i_rst_n(rst_n), .i_d_in(d_in), .i_in_valid(in_valid),
    .i_frame_sync(frame_sync), .o_y1(yl1), .o_y2(yl2), .o_y3(yl3), .o_y4(yl4),
    .o_frame_valid(fv_l), .o_sync_err(er_l), .o_locked(lk_l), .o_slot(sl_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model, index 0 = strict, 1 = lenient. A frame is a buffer
  // of collected samples; it publishes when four samples are in hand.
  logic [W-1:0] m_buf [2][4];
  logic [W-1:0] m_y   [2][4];
  int           m_cnt [2];
  logic         m_lock[2];
  logic         m_fv  [2];
  logic         m_err [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_cnt[m]  = 0;
      m_lock[m] = 1'b0;
      m_fv[m]   = 1'b0;
      m_err[m]  = 1'b0;
      for (int k = 0; k < 4; k++) begin
        m_buf[m][k] = '0;
        m_y[m][k]   = '0;
      end
    end
  endtask

  task automatic model_beat(input int m, input logic v, input logic [W-1:0] d, input logic s);
    m_fv[m]  = 1'b0;
    m_err[m] = 1'b0;
    if (v) begin
      if (!m_lock[m]) begin
        if (s) begin
          m_lock[m]     = 1'b1;
          m_buf[m][0]   = d;
          m_cnt[m]      = 1;
        end
      end else if (m_cnt[m] == 0) begin
        if (s || m == 1) begin
          m_buf[m][0] = d;
          m_cnt[m]    = 1;
        end else begin
          m_err[m]  = 1'b1;
          m_lock[m] = 1'b0;
        end
      end else if (s) begin
        m_err[m]    = 1'b1;
        m_buf[m][0] = d;
        m_cnt[m]    = 1;
      end else begin
        m_buf[m][m_cnt[m]] = d;
        m_cnt[m]++;
        if (m_cnt[m] == 4) begin
          for (int k = 0; k < 4; k++) m_y[m][k] = m_buf[m][k];
          m_fv[m]  = 1'b1;
          m_cnt[m] = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("S.y", {ys1, ys2, ys3, ys4}, {m_y[0][0], m_y[0][1], m_y[0][2], m_y[0][3]});
    chk("S.frame_valid", fv_s, m_fv[0]);
    chk("S.sync_err", er_s, m_err[0]);
    chk("S.locked", lk_s, m_lock[0]);
    chk("S.slot", sl_s, m_cnt[0]);
    chk("L.y", {yl1, yl2, yl3, yl4}, {m_y[1][0], m_y[1][1], m_y[1][2], m_y[1][3]});
    chk("L.frame_valid", fv_l, m_fv[1]);
    chk("L.sync_err", er_l, m_err[1]);
    chk("L.locked", lk_l, m_lock[1]);
    chk("L.slot", sl_l, m_cnt[1]);
  endtask

  task automatic beat(input logic v, input logic [W-1:0] d, input logic s);
    in_valid   = v;
    d_in       = d;
    frame_sync = s;
    @(posedge clk);
    model_beat(0, v, d, s);
    model_beat(1, v, d, s);
    #1;
    check_all();
  endtask

  task automatic stall(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, W'($urandom), 1'($urandom));
  endtask

  // Called 1 time unit after a rising edge; asserts reset between edges.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int tx;

  initial begin
    n_vec      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    d_in       = '0;
    frame_sync = 1'b0;
    model_reset();
    #3;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Basic frame: 1,1,0,1
    beat(1'b1, 4'h1, 1'b1);
    beat(1'b1, 4'h1, 1'b0);
    beat(1'b1, 4'h0, 1'b0);
    beat(1'b1, 4'h1, 1'b0);
    chk("t2_y", {ys1, ys2, ys3, ys4}, 32'h1101);
    chk("t2_fv", fv_s, 1'b1);
    beat(1'b0, 4'h0, 1'b0);
    chk("t2_fv_drop", fv_s, 1'b0);

    // Reset mid-frame, then clean decode
    beat(1'b1, 4'h5, 1'b1);
    beat(1'b1, 4'h6, 1'b0);
    do_reset();
    chk("t1_y_cleared", {ys1, ys2, ys3, ys4}, 32'h0);
    beat(1'b1, 4'hA, 1'b1);
    beat(1'b1, 4'hB, 1'b0);
    beat(1'b1, 4'hC, 1'b0);
    beat(1'b1, 4'hD, 1'b0);
    chk("t1_y", {ys1, ys2, ys3, ys4}, 32'hABCD);

    // HUNT: unsynced beats dropped
    do_reset();
    beat(1'b1, 4'h1, 1'b0);
    beat(1'b1, 4'h0, 1'b0);
    chk("t3_hunt", lk_s, 1'b0);
    beat(1'b1, 4'h0, 1'b1);
    chk("t3_locked", lk_s, 1'b1);
    beat(1'b1, 4'h1, 1'b0);
    beat(1'b1, 4'h1, 1'b0);
    beat(1'b1, 4'h0, 1'b0);
    chk("t3_y", {ys1, ys2, ys3, ys4}, 32'h0110);

    // Stalls between beats
    beat(1'b1, 4'h1, 1'b1); stall(3);
    beat(1'b1, 4'h1, 1'b0); stall(3);
    beat(1'b1, 4'h0, 1'b0); stall(3);
    beat(1'b1, 4'h1, 1'b0);
    chk("t4_y", {ys1, ys2, ys3, ys4}, 32'h1101);
    stall(3);

    // Early marker
    beat(1'b1, 4'h7, 1'b1);
    beat(1'b1, 4'h7, 1'b0);
    beat(1'b1, 4'h0, 1'b1);
    chk("t5_err", er_s, 1'b1);
    chk("t5_y_held", {ys1, ys2, ys3, ys4}, 32'h1101);
    beat(1'b1, 4'h1, 1'b0);
    beat(1'b1, 4'h1, 1'b0);
    beat(1'b1, 4'h1, 1'b0);
    chk("t5_y", {ys1, ys2, ys3, ys4}, 32'h0111);

    // Missing marker at slot 0
    beat(1'b1, 4'h9, 1'b0);
    chk("t6_strict_err", er_s, 1'b1);
    chk("t6_strict_locked", lk_s, 1'b0);
    chk("t6_lenient_err", er_l, 1'b0);
    chk("t6_lenient_slot", sl_l, 2'd1);

    // Random traffic: mostly well-framed, with marker faults, stalls and resets
    tx = 0;
    for (int i = 0; i < 3000; i++) begin
      logic v;
      logic s;
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
        tx = 0;
      end
      v = ($urandom_range(0, 3) != 0);
      s = (tx == 0);
      if ($urandom_range(0, 19) == 0) s = ~s;
      beat(v, W'($urandom), s);
      if (v) tx = (tx + 1) % 4;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
